// File: rtl/display_pkg.sv
// Shared display definitions: frame geometry defaults, pixel bit layout and
// the scan-out FSM state encoding used by the frame streamer.
package display_pkg;

    localparam int DEF_WIDTH  = 120;
    localparam int DEF_HEIGHT = 52;
    localparam int ROW_IDX_W  = $clog2(DEF_HEIGHT);

    typedef enum logic {
        IDLE,
        STREAM
    } out_state_e;

    // Bit position of pixel (x,y) inside a flattened frame.
    function automatic int unsigned pix_idx(input int unsigned x, input int unsigned y,
                                            input int unsigned width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/pix_row_mux.sv
// Picks row r out of a flattened WIDTH*HEIGHT frame; the only place that
// knows how frame bits map onto rows.
module pix_row_mux
    import display_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic [WIDTH*HEIGHT-1:0] frame_i,
    input  logic [RW-1:0]           row_i,
    output logic [WIDTH-1:0]        row_o
);

    logic [WIDTH-1:0] rows [HEIGHT];

    for (genvar y = 0; y < HEIGHT; y++) begin : g_row
        assign rows[y] = frame_i[pix_idx(0, y, WIDTH) +: WIDTH];
    end

    assign row_o = rows[row_i];

endmodule

// File: rtl/pix_frame_streamer.sv
// Ping-pong frame buffer that accepts whole pixel frames and scans them out
// one row per valid/ready beat.
module pix_frame_streamer
    import display_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CNT_W  = 16,
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*HEIGHT-1:0] in_pix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_row,
    output logic [RW-1:0]           out_row_idx,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic [CNT_W-1:0]        frames_done
);

    localparam logic [RW-1:0] LAST_ROW    = RW'(HEIGHT - 1);
    localparam logic          SINGLE_ROW  = (HEIGHT == 1);

    logic [WIDTH*HEIGHT-1:0] slot_q [2];
    logic [1:0]              full_q;
    logic                    wr_ptr_q, rd_ptr_q;
    out_state_e              state_q;
    logic                    out_valid_q, out_sof_q, out_eof_q;
    logic [WIDTH-1:0]        out_row_q;
    logic [RW-1:0]           out_row_idx_q;
    logic [CNT_W-1:0]        frames_done_q;

    logic                    accept, hs, last_row;
    logic                    sel_slot_d;
    logic [RW-1:0]           sel_row_d;
    logic [WIDTH-1:0]        sel_data;

    assign in_ready = !full_q[wr_ptr_q];
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid_q && out_ready;
    assign last_row = (out_row_idx_q == LAST_ROW);

    // Row the output registers load next: following row of this frame, or
    // row 0 of the other slot once the final row is taken.
    always_comb begin
        sel_slot_d = rd_ptr_q;
        sel_row_d  = '0;
        if (state_q == STREAM && hs) begin
            if (last_row) sel_slot_d = ~rd_ptr_q;
            else          sel_row_d  = out_row_idx_q + 1'b1;
        end
    end

    pix_row_mux #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RW(RW)) u_row_mux (
        .frame_i (slot_q[sel_slot_d]),
        .row_i   (sel_row_d),
        .row_o   (sel_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q        <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_row_idx_q <= '0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            frames_done_q <= '0;
        end else begin
            // The write slot is empty, so it never collides with the slot being read.
            if (accept) begin
                slot_q[wr_ptr_q] <= in_pix;
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            case (state_q)
                IDLE: begin
                    if (full_q[rd_ptr_q]) begin
                        out_valid_q   <= 1'b1;
                        out_row_q     <= sel_data;
                        out_row_idx_q <= '0;
                        out_sof_q     <= 1'b1;
                        out_eof_q     <= SINGLE_ROW;
                        state_q       <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs && !last_row) begin
                        out_row_q     <= sel_data;
                        out_row_idx_q <= sel_row_d;
                        out_sof_q     <= 1'b0;
                        out_eof_q     <= (sel_row_d == LAST_ROW);
                    end else if (hs) begin
                        full_q[rd_ptr_q] <= 1'b0;
                        rd_ptr_q         <= ~rd_ptr_q;
                        frames_done_q    <= frames_done_q + 1'b1;
                        if (full_q[~rd_ptr_q]) begin
                            out_row_q     <= sel_data;
                            out_row_idx_q <= '0;
                            out_sof_q     <= 1'b1;
                            out_eof_q     <= SINGLE_ROW;
                        end else begin
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_row_idx = out_row_idx_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_pix_frame_streamer.sv
// Directed bench for pix_frame_streamer: full-size build for the streaming
// scenarios, a tiny build for the frame counter wrap.
module tb_pix_frame_streamer;

    localparam int W  = 120;
    localparam int H  = 52;
    localparam int CW = 16;
    localparam int RW = $clog2(H);
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int SC = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W*H-1:0]   in_pix = '0;
    logic             in_ready, out_valid, out_sof, out_eof;
    logic [W-1:0]     out_row;
    logic [RW-1:0]    out_row_idx;
    logic [CW-1:0]    frames_done;

    logic             s_rst_n = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [SW*SH-1:0] s_in_pix = '0;
    logic             s_in_ready, s_out_valid, s_out_sof, s_out_eof;
    logic [SW-1:0]    s_out_row;
    logic [0:0]       s_out_row_idx;
    logic [SC-1:0]    s_frames_done;

    pix_frame_streamer #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .out_sof(out_sof),
        .out_eof(out_eof), .frames_done(frames_done)
    );

    pix_frame_streamer #(.WIDTH(SW), .HEIGHT(SH), .CNT_W(SC)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_pix(s_in_pix), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_row(s_out_row), .out_row_idx(s_out_row_idx), .out_sof(s_out_sof),
        .out_eof(s_out_eof), .frames_done(s_frames_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int seed;
        bit stall;
        int exp_done;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: diagonal (x==y); kind 1: 0xA5 ^ row ^ seed repeated across the row
    function automatic logic pix(input int kind, input int seed, input int x, input int y);
        logic [7:0] b;
        if (kind == 0) return (x == y);
        b = 8'hA5 ^ 8'(y) ^ 8'(seed);
        return b[x % 8];
    endfunction

    function automatic logic [W*H-1:0] mk_frame(input int kind, input int seed);
        logic [W*H-1:0] f;
        f = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                f[y*W + x] = pix(kind, seed, x, y);
        return f;
    endfunction

    function automatic logic [W-1:0] exp_row(input int kind, input int seed, input int y);
        logic [W-1:0] r;
        for (int x = 0; x < W; x++) r[x] = pix(kind, seed, x, y);
        return r;
    endfunction

    // Consume one frame, checking each row in order; r only advances on a
    // handshake, so a stalled row must stay put to keep matching.
    task automatic stream_frame(input int kind, input int seed, input bit stall,
                                input bit no_bubble, input string tag);
        int r = 0;
        int guard = 0;
        while (r < H && guard < 2000) begin
            guard++;
            if (out_valid) begin
                chk({tag, " idx"}, out_row_idx, r);
                chk({tag, " row"}, out_row, exp_row(kind, seed, r));
                chk({tag, " sof"}, out_sof, r == 0);
                chk({tag, " eof"}, out_eof, r == H - 1);
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) r++;
            end else begin
                if (r > 0 || no_bubble) chk({tag, " bubble"}, out_valid, 1);
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick();
        end
        if (r < H) chk({tag, " timeout"}, r, H);
    endtask

    initial begin
        tbl[0] = '{kind: 1, seed: 0,    stall: 1'b1, exp_done: 2};
        tbl[1] = '{kind: 1, seed: 7,    stall: 1'b1, exp_done: 3};
        tbl[2] = '{kind: 0, seed: 0,    stall: 1'b0, exp_done: 4};
        tbl[3] = '{kind: 1, seed: 8'h3c, stall: 1'b1, exp_done: 5};

        // reset state
        tick(); tick();
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_row", out_row, 0);
        chk("rst idx", out_row_idx, 0);
        chk("rst sof", out_sof, 0);
        chk("rst eof", out_eof, 0);
        chk("rst frames", frames_done, 0);
        rst_n = 1'b1;
        s_rst_n = 1'b1;

        // first frame latency and diagonal content
        in_pix = mk_frame(0, 0); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat edge t valid", out_valid, 0);
        chk("lat in_ready", in_ready, 1);
        tick();
        chk("lat edge t+1 valid", out_valid, 1);
        chk("row0 diag", out_row, 1);
        stream_frame(0, 0, 1'b0, 1'b1, "diag");
        chk("diag frames", frames_done, 1);
        chk("diag idle", out_valid, 0);

        // single frames, some with random sink stalls
        for (int i = 0; i < 4; i++) begin
            in_pix = mk_frame(tbl[i].kind, tbl[i].seed); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            stream_frame(tbl[i].kind, tbl[i].seed, tbl[i].stall, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d frames", i), frames_done, tbl[i].exp_done);
        end

        // two frames back to back: 104 beats without a bubble
        out_ready = 1'b1;
        in_pix = mk_frame(1, 1); in_valid = 1'b1;
        tick();
        in_pix = mk_frame(1, 2);
        tick();
        in_valid = 1'b0;
        stream_frame(1, 1, 1'b0, 1'b1, "b2b0");
        stream_frame(1, 2, 1'b0, 1'b1, "b2b1");
        chk("b2b frames", frames_done, 7);

        // both slots full, third frame waits for the final-row release
        out_ready = 1'b0;
        in_pix = mk_frame(1, 3); in_valid = 1'b1;
        tick();
        in_pix = mk_frame(1, 4);
        tick();
        in_pix = mk_frame(1, 5);
        out_ready = 1'b1;
        for (int r = 0; r < H; r++) begin
            chk("full in_ready", in_ready, 0);
            chk("full idx", out_row_idx, r);
            tick();
        end
        chk("freed in_ready", in_ready, 1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        stream_frame(1, 4, 1'b0, 1'b1, "fullD");
        stream_frame(1, 5, 1'b0, 1'b1, "fullE");
        chk("full frames", frames_done, 10);

        // reset while row 20 of slot 0 is on the output and slot 1 is full
        out_ready = 1'b0;
        in_pix = mk_frame(1, 6); in_valid = 1'b1;
        tick();
        in_pix = mk_frame(1, 7);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        out_ready = 1'b0;
        chk("pre-rst idx", out_row_idx, 20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid-rst valid", out_valid, 0);
        chk("mid-rst in_ready", in_ready, 1);
        chk("mid-rst frames", frames_done, 0);
        tick();
        chk("mid-rst discard", out_valid, 0);
        in_pix = mk_frame(0, 0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        stream_frame(0, 0, 1'b0, 1'b0, "post-rst");
        chk("post-rst frames", frames_done, 1);

        // frame counter wrap on the small build (8-bit counter, 257 frames)
        begin
            int acc = 0;
            int done = 0;
            int guard = 0;
            s_out_ready = 1'b1;
            s_in_pix = 8'h5A;
            s_in_valid = 1'b1;
            while (done < 257 && guard < 5000) begin
                bit fin;
                if (s_in_valid && s_in_ready) acc++;
                fin = s_out_valid && s_out_ready && s_out_eof;
                tick();
                guard++;
                if (acc >= 257) s_in_valid = 1'b0;
                if (fin) begin
                    done++;
                    if (done == 255) chk("wrap 255", s_frames_done, 255);
                    if (done == 256) chk("wrap 0", s_frames_done, 0);
                end
            end
            chk("wrap frame count", done, 257);
            chk("wrap value", s_frames_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pix_frame_streamer.md
Name: pix_frame_streamer

Overview:
- Receiver-side counterpart of the display circuit. It takes whole evaluated pixel frames (WIDTH*HEIGHT bits, same bit layout as the display circuit's pix output) and streams them out one row per beat to the display driver.
- Ping-pong double buffer: the evaluator can deliver frame N+1 while frame N is still being scanned out.
- Sits between the garbled-circuit evaluator output and the display/panel interface.

Parameters:
- WIDTH, 120, pixels per row.
- HEIGHT, 52, rows per frame.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  a frame is offered on in_pix.
- in_ready  output  1  a buffer slot is free.
- in_pix  input  WIDTH*HEIGHT  frame; pixel (x,y) = in_pix[y*WIDTH+x].
- out_valid  output  1  out_row holds a valid row.
- out_ready  input  1  the sink accepts the row.
- out_row  output  WIDTH  row data; bit x = pixel (x, out_row_idx).
- out_row_idx  output  $clog2(HEIGHT)  row number, 0..HEIGHT-1.
- out_sof  output  1  high with row 0.
- out_eof  output  1  high with row HEIGHT-1.
- frames_done  output  CNT_W  count of completely streamed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - both slots empty, in_ready=1;
  - out_valid=0, out_row=0, out_row_idx=0, out_sof=0, out_eof=0;
  - frames_done=0, write pointer=0, read pointer=0.
- Reset mid-operation discards all buffered and in-flight frames. No partial frame is resumed.
- Input handshake:
  - A frame is accepted when in_valid && in_ready at a rising edge. It is written into slot wr_ptr, that slot is marked full, and wr_ptr toggles.
  - in_ready = !full[wr_ptr]. It is combinational from registered state only, never from in_valid.
- Output FSM has two states.
- IDLE state:
  - out_valid=0.
  - If full[rd_ptr], load row 0 of slot rd_ptr into the output registers, assert out_valid and out_sof, and go to STREAM.
  - Latency: a frame accepted at edge t into an empty design presents row 0 after edge t+1.
- STREAM state:
  - Outputs hold stable while out_valid && !out_ready. This is standard valid/ready: no data change and no drop of valid.
  - On an out_ready handshake of row r < HEIGHT-1, present row r+1 on the next cycle (one row per cycle under continuous ready).
  - On an out_ready handshake of row HEIGHT-1 (out_eof=1):
    - clear full[rd_ptr], toggle rd_ptr, increment frames_done;
    - if the other slot is full, present its row 0 on the next cycle (back-to-back frames, no bubble) and stay in STREAM;
    - otherwise go to IDLE with out_valid=0.
- out_sof = (out_row_idx==0) && out_valid. out_eof = (out_row_idx==HEIGHT-1) && out_valid. Both are registered.
- Simultaneous events:
  - Input accept and final-row release in the same cycle are both honoured.
  - The freed slot's in_ready only rises the following cycle, because in_ready depends on registered state.
  - A write never targets the slot being read, since the write slot must be empty.
- Full: with both slots full, in_ready=0 until the final-row handshake of the current frame.
- Empty: no spurious out_valid. out_row keeps its last value (don't-care) while out_valid=0.
- HEIGHT=1: out_sof and out_eof are both high on the single row.
- Counter: frames_done wraps 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package display_pkg:
  - WIDTH/HEIGHT defaults (120/52), matching the display circuit build;
  - ROW_IDX_W = $clog2(HEIGHT);
  - pixel-index function y*WIDTH+x;
  - out-FSM state enum {IDLE, STREAM}.
- Sub-module pix_row_mux: combinational selection of row r from a WIDTH*HEIGHT frame. Instantiated once on the selected slot, so the bit-order rule lives in one place.

Test Plan:
- Reset then one frame with pix[y*120+x] = (x==y): accept at edge t, row 0 presented after edge t+1 = 0x1; row 5 has only bit 5 set; out_sof only on row 0, out_eof only on row 51; frames_done=1 after the last handshake.
- Two frames back-to-back with out_ready=1: the second frame is accepted while the first streams; 104 consecutive valid rows with no bubble; frames_done=2.
- Third frame offered while both slots are full: in_ready=0 until the row-51 handshake of frame 1, then 1 the following cycle; the frame is accepted and its content is intact.
- out_ready toggled pseudo-randomly at 50% on frame 0xA5-pattern rows: out_row and out_row_idx stay stable during stalls; every row is delivered exactly once and in order.
- rst_n low for 1 cycle while streaming row 20 of slot 0 with slot 1 full: next cycle out_valid=0, in_ready=1, frames_done=0; a new frame streams from row 0.
- 65537 frames with CNT_W=16 (small WIDTH=4, HEIGHT=2 build): frames_done wraps to 1.
